// File: rtl/word_packer.sv
// Splits a byte stream into delimiter-separated words and packs each word, null-padded,
// onto the matcher word bus. Each word is issued with cs, and one result is reported per word.
module word_packer #(
  parameter int                    WORD_LENGTH = 3,
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] DELIM       = 8'h20,
  parameter int                    IDX_WIDTH   = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_WIDTH-1:0]               in_data,
  input  logic                                in_last,
  output logic [WORD_LENGTH*DATA_WIDTH-1:0]   word,
  output logic                                cs,
  input  logic                                done,
  input  logic                                found,
  output logic                                result_valid,
  output logic                                result_found,
  output logic [$clog2(WORD_LENGTH+1)-1:0]    result_len,
  output logic                                result_trunc,
  output logic [IDX_WIDTH-1:0]                result_idx,
  output logic [1:0]                          dbg_state
);

  localparam int CW = $clog2(WORD_LENGTH + 1);
  localparam logic [CW-1:0] WL_C = CW'(WORD_LENGTH);

  typedef enum logic [1:0] {S_FILL, S_SKIP, S_ISSUE, S_RESULT} state_t;

  state_t               state, state_d;
  logic [CW-1:0]        count;
  logic                 trunc;
  logic [IDX_WIDTH-1:0] idx;
  logic                 issue_armed;
  logic                 pack_en;
  logic                 trunc_set;
  logic                 capture;

  // Handshake: a character transfers on a rising edge where in_valid & in_ready are both 1.
  // in_ready depends only on state, so the source may hold in_valid high for any length of time.
  assign in_ready     = (state == S_FILL) || (state == S_SKIP);
  assign cs           = (state == S_ISSUE);
  assign result_valid = (state == S_RESULT);
  assign dbg_state    = state;

  always_comb begin
    state_d   = state;
    pack_en   = 1'b0;
    trunc_set = 1'b0;
    capture   = 1'b0;
    case (state)
      S_FILL: begin
        if (in_valid) begin
          if (in_data != DELIM) begin
            if (count < WL_C) begin
              pack_en = 1'b1;
              if (in_last) state_d = S_ISSUE;
            end else begin
              trunc_set = 1'b1;
              state_d   = in_last ? S_ISSUE : S_SKIP;
            end
          end else if (count != '0) begin
            state_d = S_ISSUE;
          end
        end
      end
      S_SKIP: begin
        if (in_valid && ((in_data == DELIM) || in_last)) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        // The first ISSUE cycle may still see done left over from the previous word.
        if (issue_armed && done) begin
          capture = 1'b1;
          state_d = S_RESULT;
        end
      end
      S_RESULT: state_d = S_FILL;
      default:  state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_FILL;
      count        <= '0;
      trunc        <= 1'b0;
      idx          <= '0;
      word         <= '0;
      issue_armed  <= 1'b0;
      result_found <= 1'b0;
      result_len   <= '0;
      result_trunc <= 1'b0;
      result_idx   <= '0;
    end else begin
      state       <= state_d;
      issue_armed <= (state == S_ISSUE);
      if (pack_en) begin
        for (int i = 0; i < WORD_LENGTH; i++) begin
          if (CW'(WORD_LENGTH - 1 - i) == count) word[i*DATA_WIDTH +: DATA_WIDTH] <= in_data;
        end
        count <= count + CW'(1);
      end
      if (trunc_set) trunc <= 1'b1;
      if (capture) begin
        result_found <= found;
        result_len   <= count;
        result_trunc <= trunc;
        result_idx   <= idx;
      end
      if (state == S_RESULT) begin
        idx   <= idx + IDX_WIDTH'(1);
        count <= '0;
        trunc <= 1'b0;
        word  <= '0;
      end
    end
  end

endmodule
